// File: rtl/data_memory_arbiter.sv
// Two-master arbiter for a single data-memory port: round-robin grant, req/ready
// handshake through IDLE -> ACCESS -> DONE, and an abort with error on a hung memory.
module data_memory_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [DATA_SIZE-1:0] m0_wdata,
  output logic [DATA_SIZE-1:0] m0_rdata,
  output logic                 m0_ready,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [DATA_SIZE-1:0] m1_wdata,
  output logic [DATA_SIZE-1:0] m1_rdata,
  output logic                 m1_ready,
  output logic                 m1_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gid_q, gid_d;
  logic                 mreq_q, mreq_d;
  logic                 mwe_q, mwe_d;
  logic [ADDR_SIZE-1:0] maddr_q, maddr_d;
  logic [DATA_SIZE-1:0] mwdata_q, mwdata_d;
  logic [DATA_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic                 err0_q, err0_d, err1_q, err1_d;
  logic                 win;
  logic                 finish;
  logic                 timed_out;
  logic [DATA_SIZE-1:0] result;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gid_d     = gid_q;
    mreq_d    = mreq_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rdy0_d    = 1'b0;
    rdy1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    win       = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    result    = '0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the port that was not served last wins.
          win      = (m0_req && m1_req) ? ~last_q : m1_req;
          gid_d    = win;
          mwe_d    = win ? m1_we    : m0_we;
          maddr_d  = win ? m1_addr  : m0_addr;
          mwdata_d = win ? m1_wdata : m0_wdata;
          mreq_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          finish = 1'b1;
          result = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
          mreq_d  = 1'b0;
          last_d  = gid_q;
          state_d = S_DONE;
          if (gid_q) begin
            rdata1_d = result;
            rdy1_d   = 1'b1;
            err1_d   = timed_out;
          end else begin
            rdata0_d = result;
            rdy0_d   = 1'b1;
            err0_d   = timed_out;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      gid_q    <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gid_q    <= gid_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rdy0_q   <= rdy0_d;
      rdy1_q   <= rdy1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign grant_id  = gid_q;
  assign m0_rdata  = rdata0_q;
  assign m0_ready  = rdy0_q;
  assign m0_err    = err0_q;
  assign m1_rdata  = rdata1_q;
  assign m1_ready  = rdy1_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_data_memory_arbiter;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        mem_req, mem_we, grant_id;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  data_memory_arbiter #(.ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory responder settings: answer after `lat` wait cycles unless hung.
  int   lat  = 0;
  bit   hang = 1'b0;
  int   wcnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a - 32'h4B;
  endfunction

  // Reference model: one in-flight transaction, a one-cycle result pulse, then a bubble.
  bit          x_busy, x_pulse;
  int          x_waited, x_last, x_port;
  logic        x_mem_req, x_we, x_gid;
  logic [31:0] x_addr, x_wdata;
  logic [31:0] x_rdata [2];
  logic        x_ready [2];
  logic        x_err   [2];
  int          grant_log [$];

  task automatic mdl_reset();
    x_busy = 0; x_pulse = 0; x_waited = 0; x_last = 1; x_port = 0;
    x_mem_req = 0; x_we = 0; x_gid = 0; x_addr = '0; x_wdata = '0;
    for (int p = 0; p < 2; p++) begin
      x_rdata[p] = '0; x_ready[p] = 0; x_err[p] = 0;
    end
  endtask

  task automatic mdl_finish(input bit e, input logic [31:0] d);
    x_rdata[x_port] = d;
    x_ready[x_port] = 1'b1;
    x_err[x_port]   = e;
    x_mem_req = 1'b0;
    x_busy    = 0;
    x_pulse   = 1;
    x_last    = x_port;
  endtask

  task automatic mdl_step();
    if (x_pulse) begin
      x_ready[0] = 0; x_ready[1] = 0; x_err[0] = 0; x_err[1] = 0;
      x_pulse = 0;
    end else if (x_busy) begin
      if (mem_ready) mdl_finish(1'b0, mem_rdata);
      else begin
        x_waited++;
        if (x_waited >= TMO) mdl_finish(1'b1, 32'h0);
      end
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) x_port = 1 - x_last;
      else                  x_port = m1_req ? 1 : 0;
      x_gid     = (x_port == 1);
      x_we      = x_port ? m1_we    : m0_we;
      x_addr    = x_port ? m1_addr  : m0_addr;
      x_wdata   = x_port ? m1_wdata : m0_wdata;
      x_mem_req = 1'b1;
      x_busy    = 1;
      x_waited  = 0;
      grant_log.push_back(x_port);
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) mdl_reset();
      else      mdl_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("mem_req",   32'(mem_req),   32'(x_mem_req));
    chk("mem_we",    32'(mem_we),    32'(x_we));
    chk("mem_addr",  mem_addr,       x_addr);
    chk("mem_wdata", mem_wdata,      x_wdata);
    chk("grant_id",  32'(grant_id),  32'(x_gid));
    chk("m0_ready",  32'(m0_ready),  32'(x_ready[0]));
    chk("m0_err",    32'(m0_err),    32'(x_err[0]));
    chk("m0_rdata",  m0_rdata,       x_rdata[0]);
    chk("m1_ready",  32'(m1_ready),  32'(x_ready[1]));
    chk("m1_err",    32'(m1_err),    32'(x_err[1]));
    chk("m1_rdata",  m1_rdata,       x_rdata[1]);
    chk("ready_onehot", 32'(m0_ready & m1_ready), 32'h0);
  endtask

  // Advance to the next falling edge, compare, then update the memory responder.
  task automatic step();
    @(negedge clk);
    compare_all();
    if (!mem_req) begin
      wcnt = 0; mem_ready = 1'b0; mem_rdata = 32'h0;
    end else begin
      mem_ready = !hang && (wcnt == lat);
      mem_rdata = mem_ready ? mem_word(mem_addr) : 32'hBAD0_BAD0;
      wcnt++;
    end
  endtask

  task automatic wait_done(input int port, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(port == 1 ? m1_ready : m0_ready) && n < budget);
    if (!(port == 1 ? m1_ready : m0_ready)) begin
      n_vec++; n_err++;
      $display("FAIL wait_ready port %0d: no ready within %0d cycles", port, budget);
    end
  endtask

  initial begin
    int n, c0, c1, first, last_i, g;
    int reqcnt;

    // Reset state
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    rst = 1'b1;
    step();

    // Single read on port 0, two memory wait cycles
    lat = 2; m0_req = 1; m0_we = 0; m0_addr = 32'h64;
    step();
    chk("t1_mem_addr", mem_addr, 32'h64);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    n = 0;
    wait_done(0, 40, n);
    chk("t1_latency", 32'(n + 1), 32'h4);
    chk("t1_m0_rdata", m0_rdata, 32'h19);
    chk("t1_m0_err", 32'(m0_err), 32'h0);
    chk("t1_m1_ready", 32'(m1_ready), 32'h0);
    m0_req = 0;
    step();
    chk("t1_pulse_len", 32'(m0_ready), 32'h0);
    chk("t1_rdata_hold", m0_rdata, 32'h19);

    // Port 1 write
    lat = 1; m1_req = 1; m1_we = 1; m1_addr = 32'h60; m1_wdata = 32'hDEADBEEF;
    step();
    chk("t3_mem_we", 32'(mem_we), 32'h1);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    wait_done(1, 40, n);
    chk("t3_m1_rdata", m1_rdata, 32'h15);
    chk("t3_m0_untouched", m0_rdata, 32'h19);
    m1_req = 0; m1_we = 0;
    step(); step();

    // Both request continuously out of reset, zero-wait memory
    rst = 1'b0; step(); rst = 1'b1;
    grant_log.delete();
    lat = 0; m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
    c0 = 0; c1 = 0; first = -1; last_i = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m0_ready) c0++;
      if (m1_ready) c1++;
      if (m0_ready || m1_ready) begin
        if (first < 0) first = i;
        last_i = i;
      end
    end
    m0_req = 0; m1_req = 0;
    chk("t2_grants", 32'(grant_log.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : -1;
      chk("t2_grant_order", 32'(g), 32'(i % 2));
    end
    chk("t2_m0_done", 32'(c0), 32'h2);
    chk("t2_m1_done", 32'(c1), 32'h2);
    chk("t2_pulse_span", 32'(last_i - first), 32'h9);
    step(); step(); step();

    // Port 0 alone, back-to-back
    grant_log.delete();
    m0_req = 1; m0_addr = 32'h64; c0 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m0_ready) c0++;
    end
    m0_req = 0;
    chk("t6_grants", 32'(grant_log.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : -1;
      chk("t6_grant_port", 32'(g), 32'h0);
    end
    chk("t6_m0_done", 32'(c0), 32'h4);
    step(); step();

    // Timeout on a hung memory
    hang = 1; m0_req = 1; m0_addr = 32'h80; reqcnt = 0; n = 0;
    do begin
      step();
      n++;
      if (mem_req) reqcnt++;
    end while (!m0_ready && n < 40);
    chk("t4_mem_req_cycles", 32'(reqcnt), 32'd15);
    chk("t4_m0_ready", 32'(m0_ready), 32'h1);
    chk("t4_m0_err", 32'(m0_err), 32'h1);
    chk("t4_m0_rdata", m0_rdata, 32'h0);
    hang = 0; m0_req = 0;
    step();
    lat = 0; m0_req = 1; m0_addr = 32'h64;
    wait_done(0, 40, n);
    chk("t4_recover_err", 32'(m0_err), 32'h0);
    chk("t4_recover_rdata", m0_rdata, 32'h19);
    m0_req = 0;
    step(); step();

    // Reset during a long access, then a tie after release
    lat = 5; m0_req = 1; m0_addr = 32'h90;
    step(); step();
    chk("t5_in_access", 32'(mem_req), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_mem_req", 32'(mem_req), 32'h0);
    chk("t5_async_m0_ready", 32'(m0_ready), 32'h0);
    chk("t5_async_m1_ready", 32'(m1_ready), 32'h0);
    compare_all();
    m1_req = 1; m1_addr = 32'hA0;
    step();
    rst = 1'b1;
    step();
    chk("t5_tie_grant", 32'(grant_id), 32'h0);
    chk("t5_tie_addr", mem_addr, 32'h90);
    wait_done(0, 40, n);
    chk("t5_m0_rdata", m0_rdata, 32'h45);
    m0_req = 0;
    wait_done(1, 40, n);
    chk("t5_m1_rdata", m1_rdata, 32'h55);
    m1_req = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares one data-memory port (RAM or cache side, `mem_*`) between two requesters: port 0 is the core datapath, port 1 is a DMA/debug master.
- Sequences each access with a req/ready handshake and a 3-state FSM.
- Grants with round-robin priority and guards against a hung memory with a timeout that flags an error.
- Sits between the datapath/debug masters and the data memory.

Parameters:
- ADDR_SIZE, 32, address width of all ports.
- DATA_SIZE, 32, data width of all ports.
- TIMEOUT, 15, max cycles in ACCESS waiting for `mem_ready` before abort; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  port 0 access request; held high until `m0_ready`.
- m0_we  input  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  input  ADDR_SIZE  port 0 address.
- m0_wdata  input  DATA_SIZE  port 0 write data.
- m0_rdata  output  DATA_SIZE  port 0 read data; valid while `m0_ready` = 1.
- m0_ready  output  1  one-cycle completion pulse for port 0.
- m0_err  output  1  qualifies `m0_ready`: 1 means the access timed out.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready, m1_err: same as port 0, for port 1.
- mem_req  output  1  memory request; high throughout ACCESS.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_SIZE  memory address.
- mem_wdata  output  DATA_SIZE  memory write data.
- mem_rdata  input  DATA_SIZE  memory read data; valid with `mem_ready`.
- mem_ready  input  1  memory completion; sampled only in ACCESS.
- grant_id  output  1  index of the port currently or last served.

Behaviour:
Reset (`rst` = 0, asynchronous):
- state = IDLE; every output = 0.
- last_grant = 1, so port 0 wins the first tie.
- Timeout counter = 0.
- Reset asserted mid-ACCESS drops `mem_req` immediately; the in-flight transaction is lost and no ready pulse is issued.

IDLE:
- At a clock edge with any `mX_req` = 1, select a winner:
  - only one port requesting -> that port;
  - both requesting -> the port != last_grant.
- On that edge: latch the winner's we/addr/wdata into the `mem_*` output registers, set `grant_id` = winner, clear the counter, go to ACCESS.
- `mem_req` rises in the cycle after the request is sampled.

ACCESS:
- `mem_req` = 1; `mem_we`/`mem_addr`/`mem_wdata` are held stable.
- Requester inputs are ignored; a requester dropping req mid-access does not abort it.
- Edge with `mem_ready` = 1:
  - capture `mem_rdata` into the granted port's rdata register (written for reads and writes alike);
  - set that port's ready = 1 and err = 0;
  - last_grant = `grant_id`; go to DONE; `mem_req` = 0.
- Edge with `mem_ready` = 0:
  - counter += 1;
  - if the counter reaches TIMEOUT: `mem_req` = 0, granted port's ready = 1, err = 1, rdata = 0, last_grant updated, go to DONE.

DONE:
- The granted port's ready/err/rdata are visible for exactly one cycle.
- Next edge: ready = 0, err = 0, go to IDLE.
- rdata keeps its value until the next completion for that port.
- Requests are not sampled in DONE. This gives a mandatory 1-cycle bubble, so the requester can drop req before re-arbitration.

Timing:
- Zero-wait memory (`mem_ready` high in the first ACCESS cycle): req sampled at edge E, `mem_req` high E..E+1, `mX_ready` high E+1..E+2, IDLE at E+2. Throughput is one access per 3 cycles.
- Memory with L extra wait cycles: ready pulse at E+1+L.

Invariants:
- `m0_ready` and `m1_ready` are never high together.
- The non-granted port's outputs never change.
- `mem_*` outputs change only on entry to ACCESS and on exit from ACCESS, when only `mem_req` clears.

Test Plan:
- Single read, port 0, `mem_ready` 2 cycles after `mem_req`, `mem_rdata` = 0x0000_0019 -> `mem_addr` = 0x64, `mem_we` = 0; `m0_ready` pulses 1 cycle with `m0_rdata` = 0x19, `m0_err` = 0; `m1_ready` stays 0.
- Both ports request continuously out of reset, zero-wait memory -> grants 0,1,0,1 (`grant_id` alternates); one ready pulse every 3 cycles; each port gets exactly 2 of 4 completions.
- Port 1 write: addr 0x60, wdata 0xDEADBEEF, `m0_req` = 0 -> `mem_we` = 1, `mem_addr` = 0x60, `mem_wdata` = 0xDEADBEEF stable until `mem_ready`; `m1_ready` pulses; `m0_*` unchanged.
- Timeout: port 0 read, `mem_ready` never asserted, TIMEOUT = 15 -> `mem_req` high 15 cycles then 0; `m0_ready` = 1, `m0_err` = 1, `m0_rdata` = 0 for one cycle; the next port 0 request is accepted normally.
- Reset mid-ACCESS: `rst` = 0 on cycle 2 of a 5-wait access -> `mem_req` and all ready outputs drop without a clock edge; after release, a port 0/port 1 tie grants port 0.
- Only port 0 requests back-to-back for 4 accesses -> 4 consecutive port 0 grants (no forced alternation when port 1 is idle), with the 1-cycle DONE bubble between them.
